if_fetch_stage: RTL

Instruction-fetch stage of the RV32IM 5-stage pipeline. Owns the PC, runs the single-outstanding-request handshake to instruction memory, and produces the IF/ID payload: instruction, pc, pc_plus4, br_taken, plus a valid flag. It absorbs downstream stalls with a one-entry hold buffer and honours redirects (branch/jump resolution, flush) from EX.

---
 rtl/if_fetch_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding I-memory request,
// and feeds the IF/ID slot through a one-entry hold buffer. Optional BTFN prediction: IF_STATIC_PREDICT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_br_taken
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stale_q, stale_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        hold_br_q, hold_br_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_pc4_q, out_pc4_d;
  logic        out_br_q, out_br_d;

  logic        slot_free;
  logic        pred_taken;
  logic [31:0] next_pc;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

`ifdef IF_STATIC_PREDICT_EN
  logic [31:0] b_imm;

  // Backward conditional branches (negative offset) are predicted taken.
  always_comb begin
    b_imm      = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                  imem_rdata[11:8], 1'b0};
    pred_taken = (imem_rdata[6:0] == 7'b1100011) && imem_rdata[31];
    next_pc    = pred_taken ? (pc_q + b_imm) : (pc_q + 32'd4);
  end
`else
  assign pred_taken = 1'b0;
  assign next_pc    = pc_q + 32'd4;
`endif

  assign slot_free    = !out_valid_q || !stall_i;
  assign imem_read    = rst_n && (state_q != S_HOLD);
  assign imem_address = (state_q == S_DROP) ? stale_q : pc_q;

  assign if_id_valid       = out_valid_q;
  assign if_id_instruction = out_instr_q;
  assign if_id_pc          = out_pc_q;
  assign if_id_pc_plus4    = out_pc4_q;
  assign if_id_br_taken    = out_br_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_d      = stale_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_br_d    = hold_br_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_pc4_d    = out_pc4_q;
    out_br_d     = out_br_q;

    if (out_valid_q && !stall_i) begin
      out_valid_d = 1'b0;
      out_br_d    = 1'b0;
    end

    if (redirect_valid) begin
      pc_d        = {redirect_pc[31:2], 2'b00};
      out_valid_d = 1'b0;
      out_br_d    = 1'b0;
      // A request still in flight must be completed at its original address and discarded.
      case (state_q)
        S_FETCH: begin
          if (imem_resp) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_DROP;
            stale_d = pc_q;
          end
        end
        S_HOLD:  state_d = S_FETCH;
        S_DROP:  state_d = imem_resp ? S_FETCH : S_DROP;
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_resp) begin
            pc_d = next_pc;
            if (slot_free) begin
              out_valid_d = 1'b1;
              out_instr_d = imem_rdata;
              out_pc_d    = pc_q;
              out_pc4_d   = pc_q + 32'd4;
              out_br_d    = pred_taken;
            end else begin
              hold_instr_d = imem_rdata;
              hold_pc_d    = pc_q;
              hold_br_d    = pred_taken;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (slot_free) begin
            out_valid_d = 1'b1;
            out_instr_d = hold_instr_q;
            out_pc_d    = hold_pc_q;
            out_pc4_d   = hold_pc_q + 32'd4;
            out_br_d    = hold_br_q;
            state_d     = S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_resp) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      stale_q      <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      hold_br_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      out_pc4_q    <= '0;
      out_br_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stale_q      <= stale_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_br_q    <= hold_br_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_pc4_q    <= out_pc4_d;
      out_br_q     <= out_br_d;
    end
  end

endmodule
